// File: rtl/spi_peripheral_pkg.sv
// spi_peripheral_pkg: shared state encodings, SPI mode and default word width
package spi_peripheral_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;
  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;
  localparam int DEFAULT_DWIDTH = 8;
endpackage

// File: rtl/spi_sync.sv
// spi_sync: multi-flop synchronizer with configurable depth and reset value
module spi_sync #(
  parameter int STAGES = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;
  always_ff @(posedge clk or posedge rst)
    if (rst) ff <= {STAGES{RST_VAL}};
    else ff <= {ff[STAGES-2:0], d};
  assign q = ff[STAGES-1];
endmodule

// File: rtl/spi_peripheral.sv
// spi_peripheral: clk-synchronous SPI mode-0 slave with buffered host TX/RX ports
module spi_peripheral
  import spi_peripheral_pkg::*;
#(
  parameter int DWIDTH = DEFAULT_DWIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  input  logic [DWIDTH-1:0] din,
  input  logic              wr,
  output logic              tx_ready,
  output logic [DWIDTH-1:0] dout,
  output logic              rx_valid,
  input  logic              rd,
  output logic              rx_full,
  output logic              rx_ovr,
  output logic              tx_udr
);
  localparam int CW = $clog2(DWIDTH);
  logic sclk_s, ss_s, mosi_s, sclk_d, ss_d;
  logic sclk_rise, sclk_fall, ss_rise, ss_fall, last, load, wr_ok, reload;
  state_t state;
  logic [CW-1:0] bitcnt;
  logic [DWIDTH-1:0] tx_shift, rx_shift, tx_buf, tx_nxt, rx_nxt;
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sclk (.clk(clk), .rst(rst), .d(sclk), .q(sclk_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (.clk(clk), .rst(rst), .d(ss_n), .q(ss_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (.clk(clk), .rst(rst), .d(mosi), .q(mosi_s));
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_rise = ss_s & ~ss_d;
  assign ss_fall = ~ss_s & ss_d;
  assign last = bitcnt == CW'(DWIDTH - 1);
  assign tx_nxt = tx_ready ? '0 : tx_buf;
  assign rx_nxt = {rx_shift[DWIDTH-2:0], mosi_s};
  assign load = (state == ST_IDLE) ? ss_fall : (~ss_rise & sclk_fall & reload);
  // a load frees the buffer in the same cycle, so a coincident write is kept
  assign wr_ok = wr & (tx_ready | load);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sclk_d <= CPOL;
      ss_d <= 1'b1;
      state <= ST_IDLE;
      bitcnt <= '0;
      reload <= 1'b0;
      tx_shift <= '0;
      rx_shift <= '0;
      tx_buf <= '0;
      tx_ready <= 1'b1;
      miso <= 1'b0;
      dout <= '0;
      rx_valid <= 1'b0;
      rx_full <= 1'b0;
      rx_ovr <= 1'b0;
      tx_udr <= 1'b0;
    end else begin
      sclk_d <= sclk_s;
      ss_d <= ss_s;
      rx_valid <= 1'b0;
      if (wr_ok) begin
        tx_buf <= din;
        tx_ready <= 1'b0;
        tx_udr <= 1'b0;
      end else if (load) tx_ready <= 1'b1;
      if (load && tx_ready) tx_udr <= 1'b1;
      if (rd) begin
        rx_full <= 1'b0;
        rx_ovr <= 1'b0;
      end
      if (state == ST_IDLE) begin
        miso <= ss_fall ? tx_nxt[DWIDTH-1] : 1'b0;
        if (ss_fall) begin
          tx_shift <= tx_nxt;
          bitcnt <= '0;
          reload <= 1'b0;
          state <= ST_SHIFT;
        end
      end else if (ss_rise) begin
        state <= ST_IDLE;
        miso <= 1'b0;
        bitcnt <= '0;
        reload <= 1'b0;
      end else if (sclk_rise) begin
        rx_shift <= rx_nxt;
        bitcnt <= last ? '0 : bitcnt + 1'b1;
        if (last) begin
          dout <= rx_nxt;
          rx_valid <= 1'b1;
          rx_full <= 1'b1;
          reload <= 1'b1;
          if (rx_full && !rd) rx_ovr <= 1'b1;
        end
      end else if (sclk_fall) begin
        tx_shift <= reload ? tx_nxt : tx_shift << 1;
        miso <= reload ? tx_nxt[DWIDTH-1] : tx_shift[DWIDTH-2];
        reload <= 1'b0;
      end
    end
endmodule

// File: tb/tb_spi_peripheral.sv
// tb_spi_peripheral: directed scenario bench for spi_peripheral acting as SPI master and host
module tb_spi_peripheral;
  import spi_peripheral_pkg::*;
  localparam int HALF = 6;
  logic clk = 1'b0, rst, sclk, ss_n, mosi, miso, wr, rd, tx_ready, rx_valid, rx_full, rx_ovr, tx_udr;
  logic [7:0] din, dout, r1, r2;
  int checks = 0, failures = 0, vcnt = 0, v0;
  spi_peripheral dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ss_n(ss_n), .mosi(mosi), .miso(miso),
    .din(din), .wr(wr), .tx_ready(tx_ready), .dout(dout), .rx_valid(rx_valid),
    .rd(rd), .rx_full(rx_full), .rx_ovr(rx_ovr), .tx_udr(tx_udr)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (rx_valid) vcnt++;
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic host_wr(input logic [7:0] v);
    din = v;
    wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask
  task automatic host_rd();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask
  task automatic spi_word(input logic [7:0] tx, input logic rd_end, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      wait_clk(HALF);
      sclk = 1'b1;
      rx[i] = miso;
      if (i == 0 && rd_end) begin
        wait_clk(2);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        checks++;
        if (rx_valid !== 1'b1) begin
          failures++;
          $display("FAIL rdcol_rx_valid got=%b exp=1", rx_valid);
        end
        wait_clk(HALF - 3);
      end else wait_clk(HALF);
      sclk = 1'b0;
    end
  endtask
  task automatic spi_xfer(input logic [7:0] tx, input logic rd_end, output logic [7:0] rx);
    ss_n = 1'b0;
    wait_clk(HALF);
    spi_word(tx, rd_end, rx);
    wait_clk(HALF);
    ss_n = 1'b1;
    wait_clk(HALF);
  endtask
  task automatic test_reset();
    checks++;
    if ({miso, tx_ready, dout, rx_valid, rx_full, rx_ovr, tx_udr} !== {1'b0, 1'b1, 8'h00, 4'b0000}) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=%b", {miso, tx_ready, dout, rx_valid, rx_full, rx_ovr, tx_udr}, {1'b0, 1'b1, 8'h00, 4'b0000});
    end
  endtask
  task automatic test_basic();
    host_wr(8'hA5);
    checks++;
    if (tx_ready !== 1'b0) begin failures++; $display("FAIL basic_tx_ready_after_wr got=%b exp=0", tx_ready); end
    v0 = vcnt;
    spi_xfer(8'h3C, 1'b0, r1);
    checks++;
    if (r1 !== 8'hA5) begin failures++; $display("FAIL basic_master_rx got=%h exp=a5", r1); end
    checks++;
    if (dout !== 8'h3C) begin failures++; $display("FAIL basic_dout got=%h exp=3c", dout); end
    checks++;
    if (vcnt - v0 !== 1) begin failures++; $display("FAIL basic_valid_pulses got=%0d exp=1", vcnt - v0); end
    checks++;
    if ({tx_ready, rx_full, rx_ovr} !== 3'b110) begin failures++; $display("FAIL basic_flags got=%b exp=110", {tx_ready, rx_full, rx_ovr}); end
    host_rd();
    checks++;
    if (rx_full !== 1'b0) begin failures++; $display("FAIL basic_rd_clear got=%b exp=0", rx_full); end
  endtask
  task automatic test_back_to_back();
    host_wr(8'h55);
    v0 = vcnt;
    ss_n = 1'b0;
    wait_clk(HALF);
    checks++;
    if (tx_ready !== 1'b1) begin failures++; $display("FAIL b2b_tx_ready_after_load got=%b exp=1", tx_ready); end
    host_wr(8'hAA);
    spi_word(8'h11, 1'b0, r1);
    spi_word(8'h22, 1'b0, r2);
    wait_clk(HALF);
    ss_n = 1'b1;
    wait_clk(HALF);
    checks++;
    if ({r1, r2} !== 16'h55AA) begin failures++; $display("FAIL b2b_master_rx got=%h exp=55aa", {r1, r2}); end
    checks++;
    if (dout !== 8'h22) begin failures++; $display("FAIL b2b_dout got=%h exp=22", dout); end
    checks++;
    if ({rx_full, rx_ovr} !== 2'b11) begin failures++; $display("FAIL b2b_overrun got=%b exp=11", {rx_full, rx_ovr}); end
    checks++;
    if (vcnt - v0 !== 2) begin failures++; $display("FAIL b2b_valid_pulses got=%0d exp=2", vcnt - v0); end
  endtask
  task automatic test_underrun();
    spi_xfer(8'hF0, 1'b0, r1);
    checks++;
    if (r1 !== 8'h00) begin failures++; $display("FAIL udr_master_rx got=%h exp=00", r1); end
    checks++;
    if ({tx_udr, dout} !== {1'b1, 8'hF0}) begin failures++; $display("FAIL udr_flag_dout got=%h exp=1f0", {tx_udr, dout}); end
    host_wr(8'h12);
    checks++;
    if ({tx_udr, tx_ready} !== 2'b00) begin failures++; $display("FAIL udr_wr_clear got=%b exp=00", {tx_udr, tx_ready}); end
  endtask
  task automatic test_abort();
    logic [7:0] p = 8'hC3;
    v0 = vcnt;
    ss_n = 1'b0;
    wait_clk(HALF);
    for (int i = 7; i >= 4; i--) begin
      mosi = p[i];
      wait_clk(HALF);
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
    end
    wait_clk(HALF);
    ss_n = 1'b1;
    wait_clk(HALF);
    checks++;
    if (vcnt - v0 !== 0) begin failures++; $display("FAIL abort_no_valid got=%0d exp=0", vcnt - v0); end
    checks++;
    if ({dout, miso} !== {8'hF0, 1'b0}) begin failures++; $display("FAIL abort_dout_miso got=%h exp=1e0", {dout, miso}); end
    checks++;
    if (dut.state !== ST_IDLE) begin failures++; $display("FAIL abort_state got=%b exp=0", dut.state); end
    spi_xfer(8'h81, 1'b0, r1);
    checks++;
    if ({dout, r1} !== 16'h8100) begin failures++; $display("FAIL abort_next_word got=%h exp=8100", {dout, r1}); end
  endtask
  task automatic test_rd_collision();
    host_rd();
    checks++;
    if ({rx_full, rx_ovr} !== 2'b00) begin failures++; $display("FAIL rdcol_clear got=%b exp=00", {rx_full, rx_ovr}); end
    spi_xfer(8'h33, 1'b0, r1);
    spi_xfer(8'h7E, 1'b1, r1);
    checks++;
    if ({rx_full, rx_ovr, dout} !== {2'b10, 8'h7E}) begin failures++; $display("FAIL rdcol_flags_dout got=%h exp=27e", {rx_full, rx_ovr, dout}); end
  endtask
  task automatic test_reset_mid();
    logic [7:0] p = 8'h99;
    host_wr(8'h96);
    ss_n = 1'b0;
    wait_clk(HALF);
    for (int i = 7; i >= 4; i--) begin
      mosi = p[i];
      wait_clk(HALF);
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
    end
    mosi = p[3];
    wait_clk(HALF);
    sclk = 1'b1;
    wait_clk(4);
    rst = 1'b1;
    #1;
    checks++;
    if ({miso, tx_ready, dout, rx_valid, rx_full, rx_ovr, tx_udr} !== {1'b0, 1'b1, 8'h00, 4'b0000}) begin
      failures++;
      $display("FAIL midrst_outputs got=%b exp=%b", {miso, tx_ready, dout, rx_valid, rx_full, rx_ovr, tx_udr}, {1'b0, 1'b1, 8'h00, 4'b0000});
    end
    sclk = 1'b0;
    ss_n = 1'b1;
    mosi = 1'b0;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(3);
    host_wr(8'hC3);
    v0 = vcnt;
    spi_xfer(8'h5A, 1'b0, r1);
    checks++;
    if ({dout, r1} !== 16'h5AC3) begin failures++; $display("FAIL midrst_next_word got=%h exp=5ac3", {dout, r1}); end
    checks++;
    if (vcnt - v0 !== 1) begin failures++; $display("FAIL midrst_valid_pulses got=%0d exp=1", vcnt - v0); end
  endtask
  initial begin
    rst = 1'b1;
    sclk = 1'b0;
    ss_n = 1'b1;
    mosi = 1'b0;
    wr = 1'b0;
    rd = 1'b0;
    din = '0;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(2);
    test_reset();
    test_basic();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_rd_collision();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
